// File: rtl/seg_pkg.sv
// Shared types and constants for the countdown display back-end.
// Segment patterns are active-high, bit 0 = a .. bit 6 = g.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble: 8-bit binary to 3 BCD digits.
// One shift per cycle; done_o marks the cycle the accumulator is final.
module seg_bin2bcd
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  bin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [11:0] bcd_o
);

  conv_state_e state_q;
  logic        busy_q;
  logic [2:0]  cnt_q;
  logic [7:0]  bin_q;
  logic [11:0] acc_q;
  logic [11:0] adj_d;

  always_comb begin
    adj_d = acc_q;
    for (int i = 0; i < 3; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5)
        adj_d[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            bin_q   <= bin_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          {acc_q, bin_q} <= {adj_d[10:0], bin_q, 1'b0};
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7)
            state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = (state_q == DONE);
  assign bcd_o  = acc_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Countdown display back-end: BCD conversion with a one-deep pending
// buffer, 3-digit multiplexed scan, leading-zero blanking, pin polarity.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  value_in,
  input  logic        value_vld,
  output logic        busy,
  output logic [7:0]  seg,
  output logic [2:0]  dig,
  output logic [11:0] bcd_out
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
  localparam logic [7:0] SEG_RST =
    (SEG_ACTIVE_LOW != 0) ? ~{1'b0, SEG_0} : {1'b0, SEG_0};
  localparam logic [2:0] DIG_RST =
    (DIG_ACTIVE_LOW != 0) ? 3'b110 : 3'b001;

  logic          busy_w, done_w, start_w;
  logic [7:0]    bin_w;
  logic [11:0]   acc_w;
  logic [7:0]    pend_q;
  logic          pend_vld_q;
  logic [11:0]   bcd_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [7:0]    seg_q, seg_d;
  logic [2:0]    dig_q, dig_d;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    pat;

  // A fresh strobe beats a stale pending value.
  assign start_w = !busy_w && (value_vld || pend_vld_q);
  assign bin_w   = value_vld ? value_in : pend_q;

  seg_bin2bcd u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_w),
    .bin_i   (bin_w),
    .busy_o  (busy_w),
    .done_o  (done_w),
    .bcd_o   (acc_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      bcd_q      <= '0;
    end else begin
      if (busy_w && value_vld) begin
        pend_q     <= value_in;
        pend_vld_q <= 1'b1;
      end else if (start_w) begin
        pend_vld_q <= 1'b0;
      end
      if (done_w)
        bcd_q <= acc_w;
    end
  end

  always_comb begin
    nib   = bcd_q[3:0];
    blank = 1'b0;
    unique case (idx_q)
      DIG_TENS: begin
        nib   = bcd_q[7:4];
        blank = (BLANK_LZ != 0) && (bcd_q[11:4] == 8'd0);
      end
      DIG_HUND: begin
        nib   = bcd_q[11:8];
        blank = (BLANK_LZ != 0) && (bcd_q[11:8] == 4'd0);
      end
      default: ;
    endcase
    pat   = blank ? SEG_BLANK : seg7(nib);
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~{1'b0, pat} : {1'b0, pat};
    dig_d = 3'b001 << idx_q;
    if (DIG_ACTIVE_LOW != 0)
      dig_d = ~dig_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= DIG_ONES;
      seg_q   <= SEG_RST;
      dig_q   <= DIG_RST;
    end else begin
      if (presc_q == PMAX) begin
        presc_q <= '0;
        idx_q   <= (idx_q == DIG_HUND) ? DIG_ONES : idx_q + 2'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign busy    = busy_w;
  assign bcd_out = bcd_q;
  assign seg     = seg_q;
  assign dig     = dig_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench: u0 uses default polarity/blanking, u1 is active-high
// with blanking off; both share stimulus and scan in lock-step.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  value_in = '0;
  logic        value_vld = 1'b0;
  logic        busy0, busy1;
  logic [7:0]  seg0, seg1;
  logic [2:0]  dig0, dig1;
  logic [11:0] bcd0, bcd1;
  int          n_run = 0;
  int          n_fail = 0;
  logic        seen15 = 1'b0;

  localparam logic [6:0] P0 = 7'h3F;
  localparam logic [6:0] P1 = 7'h06;
  localparam logic [6:0] P2 = 7'h5B;
  localparam logic [6:0] P3 = 7'h4F;
  localparam logic [6:0] P5 = 7'h6D;
  localparam logic [6:0] PB = 7'h00;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV(4), .SEG_ACTIVE_LOW(1),
    .DIG_ACTIVE_LOW(1), .BLANK_LZ(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .value_in(value_in), .value_vld(value_vld),
    .busy(busy0), .seg(seg0), .dig(dig0),
    .bcd_out(bcd0)
  );

  seg_scan_driver #(
    .SCAN_DIV(4), .SEG_ACTIVE_LOW(0),
    .DIG_ACTIVE_LOW(0), .BLANK_LZ(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .value_in(value_in), .value_vld(value_vld),
    .busy(busy1), .seg(seg1), .dig(dig1),
    .bcd_out(bcd1)
  );

  always @(negedge clk)
    if (bcd0 == 12'h015) seen15 <= 1'b1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge after the capture edge E0.
  task automatic send(input logic [7:0] v);
    value_in  = v;
    value_vld = 1'b1;
    @(negedge clk);
    value_vld = 1'b0;
  endtask

  task automatic show(input string tag, input int idx,
                      input logic [6:0] e0,
                      input logic [6:0] e1);
    logic [2:0] oh;
    int n;
    oh = 3'b001 << idx;
    n = 0;
    @(negedge clk);
    while (dig0 != ~oh && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".wait"}, n < 20, 1);
    check({tag, ".seg0"}, seg0, {1'b1, ~e0});
    check({tag, ".dig1"}, dig1, oh);
    check({tag, ".seg1"}, seg1, {1'b0, e1});
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    cyc(2);
    check("rst.busy", busy0, 0);
    check("rst.bcd", bcd0, 12'h000);
    check("rst.dig0", dig0, 3'b110);
    check("rst.seg0", seg0, 8'hC0);
    check("rst.dig1", dig1, 3'b001);
    check("rst.seg1", seg1, 8'h3F);
    rst_n = 1'b1;

    // 1: idle scan of 000
    show("t1.ones", 0, P0, P0);
    show("t1.tens", 1, PB, P0);
    show("t1.hund", 2, PB, P0);
    n = 0;
    while (dig0 != 3'b101 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (dig0 == 3'b101 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t1.hold", n, 4);

    // 2: value 30, busy width and latency
    send(8'd30);
    n = 0;
    while (busy0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("t2.busy_len", n, 9);
    check("t2.bcd", bcd0, 12'h030);
    show("t2.ones", 0, P0, P0);
    show("t2.tens", 1, P3, P3);
    show("t2.hund", 2, PB, P0);

    // 3: full range and an interior zero
    send(8'd255);
    cyc(9);
    check("t3.bcd255", bcd0, 12'h255);
    show("t3.ones", 0, P5, P5);
    show("t3.tens", 1, P5, P5);
    show("t3.hund", 2, P2, P2);
    send(8'd100);
    cyc(9);
    check("t3.bcd100", bcd0, 12'h100);
    show("t3.tens0", 1, P0, P0);
    show("t3.hund1", 2, P1, P1);

    // 4: pending buffer, last write wins
    send(8'd30);
    cyc(2);
    value_in = 8'd15; value_vld = 1'b1;
    cyc(1);
    value_vld = 1'b0;
    cyc(1);
    value_in = 8'd7; value_vld = 1'b1;
    cyc(1);
    value_vld = 1'b0;
    cyc(4);
    check("t4.bcd30", bcd0, 12'h030);
    cyc(9);
    check("t4.hold30", bcd0, 12'h030);
    cyc(1);
    check("t4.bcd7", bcd0, 12'h007);
    check("t4.no15", seen15, 0);

    // 5: reset mid-conversion
    send(8'd45);
    cyc(3);
    rst_n = 1'b0;
    #1;
    check("t5.busy", busy0, 0);
    check("t5.bcd", bcd0, 12'h000);
    check("t5.dig0", dig0, 3'b110);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    send(8'd12);
    cyc(8);
    check("t5.early", bcd0, 12'h000);
    cyc(1);
    check("t5.bcd12", bcd0, 12'h012);
    check("t5.bcd12b", bcd1, 12'h012);

    // 6: blanking on/off, value 5 then 0
    send(8'd5);
    cyc(9);
    show("t6.ones5", 0, P5, P5);
    show("t6.tens5", 1, PB, P0);
    show("t6.hund5", 2, PB, P0);
    send(8'd0);
    cyc(9);
    check("t6.bcd0", bcd0, 12'h000);
    show("t6.ones0", 0, P0, P0);
    show("t6.tens0", 1, PB, P0);
    show("t6.hund0", 2, PB, P0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
